// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: pin sync, ps2_clk deglitch, 11-bit deserialiser, byte/error strobes.
// Define PS2_RX_TIMEOUT_EN to enable the watchdog that aborts a stalled frame (err[3]).
module ps2_rx #(
    parameter int unsigned FILT_LEN    = 4,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scode,
    output logic       scode_en,
    output logic [7:0] err
);
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    if (FILT_LEN < 2 || TIMEOUT_CYC < 2) begin : g_param_check
        $error("ps2_rx: FILT_LEN and TIMEOUT_CYC must both be >= 2");
    end

    logic [1:0]          clk_sync;
    logic [1:0]          data_sync;
    logic [FILT_LEN-1:0] clk_hist;
    logic                filt;
    logic                filt_q;
    logic                fall;
    logic                data_s;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             acc, acc_d;
    logic             par_ok, par_ok_d;
    logic [7:0]       byte_q, byte_d;
    logic [7:0]       scode_d;
    logic             scode_en_d;
    logic [7:0]       err_d;

    // Synchronisers and level filter reset high so release from reset never looks like an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_hist  <= '1;
            filt      <= 1'b1;
            filt_q    <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_hist  <= {clk_hist[FILT_LEN-2:0], clk_sync[1]};
            if (&clk_hist) begin
                filt <= 1'b1;
            end else if (~|clk_hist) begin
                filt <= 1'b0;
            end
            filt_q <= filt;
        end
    end

    assign fall   = filt_q & ~filt;
    assign data_s = data_sync[1];

`ifdef PS2_RX_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC);

    logic            clk_edge;
    logic [WD_W-1:0] wdog, wdog_d;

    assign clk_edge = filt_q ^ filt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog <= '0;
        end else begin
            wdog <= wdog_d;
        end
    end
`endif

    // FSM and output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= 1'b0;
            par_ok   <= 1'b0;
            byte_q   <= '0;
            scode    <= '0;
            scode_en <= 1'b0;
            err      <= '0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            acc      <= acc_d;
            par_ok   <= par_ok_d;
            byte_q   <= byte_d;
            scode    <= scode_d;
            scode_en <= scode_en_d;
            err      <= err_d;
        end
    end

    // Next state: every step is taken only on a filtered ps2_clk fall
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        acc_d      = acc;
        par_ok_d   = par_ok;
        byte_d     = byte_q;
        scode_d    = scode;
        scode_en_d = 1'b0;
        err_d      = '0;

        if (fall) begin
            case (state)
                IDLE: begin
                    if (!data_s) begin
                        state_d = DATA;
                        cnt_d   = '0;
                        acc_d   = 1'b0;
                    end else begin
                        err_d[2] = 1'b1;
                    end
                end
                DATA: begin
                    byte_d[cnt] = data_s;
                    acc_d       = acc ^ data_s;
                    cnt_d       = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(7)) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    par_ok_d = acc ^ data_s;
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!data_s) begin
                        err_d[1] = 1'b1;
                    end else if (par_ok) begin
                        scode_d    = byte_q;
                        scode_en_d = 1'b1;
                    end else begin
                        err_d[0] = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

`ifdef PS2_RX_TIMEOUT_EN
        // Timeout can only fire in a cycle with no filtered edge, so it never races a fall
        wdog_d = wdog;
        if (state == IDLE || clk_edge) begin
            wdog_d = '0;
        end else if (wdog == WD_W'(TIMEOUT_CYC - 1)) begin
            wdog_d   = '0;
            state_d  = IDLE;
            err_d[3] = 1'b1;
        end else begin
            wdog_d = wdog + WD_W'(1);
        end
`endif
    end

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: randomized PS/2 frames, queue scoreboard, decoupled output monitor.
module tb_ps2_rx;
    localparam int unsigned FILT_LEN    = 4;
    localparam int unsigned TIMEOUT_CYC = 400;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] scode;
    logic       scode_en;
    logic [7:0] err;

    ps2_rx #(.FILT_LEN(FILT_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .scode    (scode),
        .scode_en (scode_en),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] scode;
        logic       en;
        logic [7:0] err;
        bit         chk_lat;
    } exp_t;

    exp_t       exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         last_fall = 0;
    logic [7:0] model_scode = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: every scode_en or err pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (!rst && (scode_en || err != 8'h00)) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: scode_en=%0b err=%02h scode=%02h, required no output",
                         scode_en, err, scode);
            end else begin
                exp_t e;
                int   lat;
                e = exp_q.pop_front();
                check("scode_en", int'(scode_en), int'(e.en));
                check("err", int'(err), int'(e.err));
                check("scode", int'(scode), int'(e.scode));
                if (e.chk_lat) begin
                    lat = cyc - last_fall;
                    check("latency_ok", int'(lat == FILT_LEN + 4 || lat == FILT_LEN + 5), 1);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One PS/2 bit: data set while clock high, 30-cycle low phase; optional short low glitch after the rise
    task automatic ps2_bit(input logic b, input bit glitch);
        ps2_data = b;
        tick(15);
        ps2_clk   = 1'b0;
        last_fall = cyc;
        tick(30);
        ps2_clk = 1'b1;
        tick(5);
        if (glitch) begin
            ps2_clk = 1'b0;
            tick(FILT_LEN - 1);
            ps2_clk = 1'b1;
        end
        tick(10);
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic par, input logic stop);
        return {stop, par, d, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int lo, input int hi, input int glitch_at);
        for (int i = lo; i <= hi; i++) ps2_bit(f[i], i == glitch_at);
    endtask

    // Reference: stop bit checked first, then odd parity over the 8 data bits plus parity bit
    task automatic expect_frame(input logic [7:0] d, input logic par, input logic stop);
        exp_t e;
        e.chk_lat = 1'b1;
        if (!stop) begin
            e.scode = model_scode; e.en = 1'b0; e.err = 8'h02;
        end else if ((($countones(d) + int'(par)) % 2) == 1) begin
            model_scode = d;
            e.scode = d; e.en = 1'b1; e.err = 8'h00;
        end else begin
            e.scode = model_scode; e.en = 1'b0; e.err = 8'h01;
        end
        exp_q.push_back(e);
    endtask

    function automatic logic good_par(input logic [7:0] d);
        return logic'(($countones(d) % 2) == 0);
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int glitch_at);
        expect_frame(d, par, stop);
        send_bits(mk_frame(d, par, stop), 0, 10, glitch_at);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        exp_t       e;
        logic [7:0] d;
        logic [10:0] f;
        int         kind;

        tick(5);
        check("reset_scode", int'(scode), 0);
        check("reset_scode_en", int'(scode_en), 0);
        check("reset_err", int'(err), 0);
        rst = 1'b0;
        tick(20);

        // Directed frames: single, back-to-back break sequence, parity and stop faults
        send_frame(8'h1C, good_par(8'h1C), 1'b1, -1);
        send_frame(8'hF0, good_par(8'hF0), 1'b1, -1);
        send_frame(8'h1C, good_par(8'h1C), 1'b1, -1);
        send_frame(8'h1C, ~good_par(8'h1C), 1'b1, -1);
        send_frame(8'h1C, good_par(8'h1C), 1'b0, -1);

        // Short glitch in IDLE, then a frame with a glitch mid-data
        ps2_clk = 1'b0;
        tick(FILT_LEN - 1);
        ps2_clk = 1'b1;
        tick(30);
        send_frame(8'h1C, good_par(8'h1C), 1'b1, 4);

        // Lone fall with data high in IDLE
        e.scode = model_scode; e.en = 1'b0; e.err = 8'h04; e.chk_lat = 1'b1;
        exp_q.push_back(e);
        ps2_bit(1'b1, 1'b0);
        tick(20);

        // Stall after start plus five data bits
        d = 8'hA5;
        f = mk_frame(d, good_par(d), 1'b1);
`ifdef PS2_RX_TIMEOUT_EN
        e.scode = model_scode; e.en = 1'b0; e.err = 8'h08; e.chk_lat = 1'b0;
        exp_q.push_back(e);
        send_bits(f, 0, 5, -1);
        tick(TIMEOUT_CYC + 200);
        check("timeout_reported", int'(exp_q.size()), 0);
        send_frame(8'hF0, good_par(8'hF0), 1'b1, -1);
`else
        expect_frame(d, good_par(d), 1'b1);
        send_bits(f, 0, 5, -1);
        tick(3 * TIMEOUT_CYC);
        send_bits(f, 6, 10, -1);
`endif
        tick(20);

        // Reset in the middle of a data phase, then a clean frame
        f = mk_frame(8'h77, good_par(8'h77), 1'b1);
        send_bits(f, 0, 3, -1);
        rst = 1'b1;
        #1;
        check("midrst_scode", int'(scode), 0);
        check("midrst_scode_en", int'(scode_en), 0);
        check("midrst_err", int'(err), 0);
        model_scode = 8'h00;
        ps2_data = 1'b1;
        tick(5);
        rst = 1'b0;
        tick(20);
        send_frame(8'h1C, good_par(8'h1C), 1'b1, -1);

        // Randomized frames: mostly good, some parity/stop faults, occasional glitches
        for (int n = 0; n < 20; n++) begin
            d    = 8'($urandom);
            kind = int'($urandom_range(0, 5));
            send_frame(d, (kind == 0) ? ~good_par(d) : good_par(d), logic'(kind != 1),
                       ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 10)) : -1);
            if ($urandom_range(0, 2) == 0) tick(int'($urandom_range(1, 50)));
        end

        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missing_output: no pulse seen, required scode_en=%0b err=%02h", e.en, e.err);
        end
        tick(10);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
